// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer: FSM states, field widths,
// tempo tick length and the ROM field encodings for rests and end-of-song.
package tone_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_PLAY,
      S_DONE
   } state_t;

   localparam int HALF_W_DEF = 16;
   localparam int DUR_W_DEF  = 8;

   localparam int END_DUR   = 0;
   localparam int REST_HALF = 0;

   function automatic int tick_cycles(input int clk_freq, input int tempo_hz);
      return clk_freq / tempo_hz;
   endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles frq every `half` enabled clocks; a zero
// half-period is a rest and keeps frq low.
module tone_divider
   import tone_seq_pkg::*;
#(
   parameter int HALF_W = HALF_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [HALF_W-1:0] half,
   output logic              frq
);

   logic [HALF_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         frq <= 1'b0;
      end else if (clr || half == HALF_W'(REST_HALF)) begin
         cnt <= '0;
         frq <= 1'b0;
      end else if (en) begin
         if (cnt == half - HALF_W'(1)) begin
            cnt <= '0;
            frq <= ~frq;
         end else begin
            cnt <= cnt + HALF_W'(1);
         end
      end
   end

endmodule

// File: rtl/tone_sequencer.sv
// Melody player: walks a song ROM of (half-period, duration) entries, holding
// each note for duration tempo ticks and driving the codec tone level.
module tone_sequencer
   import tone_seq_pkg::*;
#(
   parameter int CLK_FREQ = 18432000,
   parameter int TEMPO_HZ = 16,
   parameter int ADDR_W   = 6,
   parameter int HALF_W   = HALF_W_DEF,
   parameter int DUR_W    = DUR_W_DEF
) (
   input  logic                    iCLK_18_4,
   input  logic                    sys_rst,
   input  logic                    iStart,
   input  logic                    iStop,
   input  logic                    iLoop,
   output logic [ADDR_W-1:0]       oAddr,
   input  logic [HALF_W+DUR_W-1:0] iData,
   output logic                    oFrq,
   output logic                    oBusy,
   output logic                    oDone
);

   localparam int TICK_CYCLES = tick_cycles(CLK_FREQ, TEMPO_HZ);
   localparam int TICK_W      = $clog2(TICK_CYCLES);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   state_t            state;
   logic [TICK_W-1:0] tick_cnt;
   logic [HALF_W-1:0] half_reg;
   logic [DUR_W-1:0]  dur_reg;
   logic              tick_tc, note_end, tone_en, tone_clr;

   assign tick_tc  = (tick_cnt == TICK_LAST);
   assign tone_en  = (state == S_PLAY);
   assign note_end = tone_en && tick_tc && (dur_reg == DUR_W'(1));
   // Tone is forced silent outside PLAY and on the note-ending edge
   assign tone_clr = iStop || !tone_en || note_end;

   always_ff @(posedge iCLK_18_4 or posedge sys_rst) begin
      if (sys_rst) begin
         state    <= S_IDLE;
         oAddr    <= '0;
         oBusy    <= 1'b0;
         oDone    <= 1'b0;
         tick_cnt <= '0;
         half_reg <= '0;
         dur_reg  <= '0;
      end else begin
         oDone <= 1'b0;
         if (iStop) begin
            state    <= S_IDLE;
            oAddr    <= '0;
            oBusy    <= 1'b0;
            tick_cnt <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  oAddr    <= '0;
                  tick_cnt <= '0;
                  if (iStart) begin
                     state <= S_FETCH;
                     oBusy <= 1'b1;
                  end
               end
               S_FETCH: state <= S_LATCH;
               S_LATCH: begin
                  half_reg <= iData[HALF_W+DUR_W-1:DUR_W];
                  dur_reg  <= iData[DUR_W-1:0];
                  tick_cnt <= '0;
                  if (iData[DUR_W-1:0] == DUR_W'(END_DUR)) begin
                     state <= S_DONE;
                     oDone <= 1'b1;
                  end else begin
                     state <= S_PLAY;
                  end
               end
               S_PLAY: begin
                  if (tick_tc) begin
                     tick_cnt <= '0;
                     dur_reg  <= dur_reg - DUR_W'(1);
                     if (note_end) begin
                        if (oAddr != ADDR_LAST) begin
                           oAddr <= oAddr + ADDR_W'(1);
                           state <= S_FETCH;
                        end else if (iLoop) begin
                           oAddr <= '0;
                           state <= S_FETCH;
                        end else begin
                           state <= S_DONE;
                           oDone <= 1'b1;
                        end
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
                  oAddr <= '0;
                  oBusy <= 1'b0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   tone_divider #(.HALF_W(HALF_W)) u_div (
      .clk  (iCLK_18_4),
      .rst  (sys_rst),
      .clr  (tone_clr),
      .en   (tone_en),
      .half (half_reg),
      .frq  (oFrq)
   );

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: a note-level model expands the song ROM into the
// expected per-cycle {addr, frq, busy, done} trace.
module tb_tone_sequencer;

   localparam int AW = 2;
   localparam int HW = 16;
   localparam int DW = 8;
   localparam int T  = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, stop = 1'b0, loop = 1'b0;
   logic [AW-1:0] addr;
   logic [HW+DW-1:0] data;
   logic          frq, busy, done;
   logic [HW+DW-1:0] rom [4];
   logic [4:0]    exp_q [$];
   int            checks = 0;
   int            errors = 0;

   tone_sequencer #(
      .CLK_FREQ(1000), .TEMPO_HZ(100), .ADDR_W(AW), .HALF_W(HW), .DUR_W(DW)
   ) dut (
      .iCLK_18_4(clk), .sys_rst(rst), .iStart(start), .iStop(stop),
      .iLoop(loop), .oAddr(addr), .iData(data), .oFrq(frq),
      .oBusy(busy), .oDone(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) data <= rom[addr];

   // Expected trace, one entry per edge starting at the start-sample edge.
   task automatic gen_trace(input int wraps);
      int a = 0;
      int w = wraps;
      int h, d;
      exp_q.delete();
      forever begin
         exp_q.push_back({2'(a), 3'b010});
         exp_q.push_back({2'(a), 3'b010});
         h = int'(rom[a][HW+DW-1:DW]);
         d = int'(rom[a][DW-1:0]);
         if (d == 0) begin
            exp_q.push_back({2'(a), 3'b011});
            exp_q.push_back(5'b0);
            break;
         end
         for (int t = 0; t < d*T; t++)
            exp_q.push_back({2'(a), (h == 0) ? 1'b0 : 1'((t / h) % 2), 2'b10});
         if (a < 3) a++;
         else if (w > 0) begin w--; a = 0; end
         else begin
            exp_q.push_back({2'(a), 3'b011});
            exp_q.push_back(5'b0);
            break;
         end
      end
   endtask

   // start_mode: 0 single pulse, 1 random start noise while busy, 2 held high
   task automatic run_song(input int wraps, input int loop_until, input int stop_at,
                           input int start_mode, output int busy_cyc, output int done_cyc);
      int len;
      logic [4:0] got, want;
      gen_trace(wraps);
      len = (stop_at >= 0) ? stop_at + 4 : exp_q.size();
      busy_cyc = 0;
      done_cyc = 0;
      start = 1'b0; stop = 1'b0; loop = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      loop  = (0 < loop_until);
      for (int n = 0; n < len; n++) begin
         @(posedge clk);
         #1;
         want = (stop_at >= 0 && n >= stop_at) ? 5'b0 : exp_q[n];
         got  = {addr, frq, busy, done};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL trace[%0d]: got addr=%0d frq=%b busy=%b done=%b, want addr=%0d frq=%b busy=%b done=%b",
                     n, got[4:3], got[2], got[1], got[0], want[4:3], want[2], want[1], want[0]);
         end
         busy_cyc += (busy === 1'b1) ? 1 : 0;
         done_cyc += (done === 1'b1) ? 1 : 0;
         if (start_mode == 2) start = 1'b1;
         else if (start_mode == 1 && n + 1 < len) start = 1'($urandom_range(0, 1));
         else start = 1'b0;
         loop = (n + 1 < loop_until);
         stop = (n + 1 == stop_at);
      end
      if (start_mode == 2) begin
         @(posedge clk);
         #1;
         checks++;
         if (busy !== 1'b1 || addr !== 2'd0) begin
            errors++;
            $display("FAIL restart: got busy=%b addr=%0d, want busy=1 addr=0", busy, addr);
         end
         start = 1'b0;
         stop  = 1'b1;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      stop  = 1'b0;
      loop  = 1'b0;
   endtask

   task automatic rand_rom();
      for (int i = 0; i < 4; i++)
         rom[i] = {16'($urandom_range(0, 4)), 8'($urandom_range(0, 3))};
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) rom[i] = '0;
      rst = 1'b1;
      #12;
      checks++;
      if ({addr, frq, busy, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset: got addr=%0d frq=%b busy=%b done=%b, want all 0", addr, frq, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_note();
      int b, d;
      rom[0] = {16'd3, 8'd2}; rom[1] = '0; rom[2] = '0; rom[3] = '0;
      run_song(0, 0, -1, 0, b, d);
      checks++;
      if (b != 25) begin errors++; $display("FAIL single_busy: got %0d cycles, want 25", b); end
      checks++;
      if (d != 1) begin errors++; $display("FAIL single_done: got %0d pulses, want 1", d); end
   endtask

   task automatic test_rest();
      int b, d;
      rom[0] = {16'd0, 8'd3}; rom[1] = {16'd5, 8'd1}; rom[2] = '0; rom[3] = '0;
      run_song(0, 0, -1, 0, b, d);
      checks++;
      if (d != 1) begin errors++; $display("FAIL rest_done: got %0d pulses, want 1", d); end
   endtask

   task automatic test_loop();
      int b, d;
      for (int i = 0; i < 4; i++) rom[i] = {16'd2, 8'd1};
      run_song(2, 100, -1, 0, b, d);
      checks++;
      if (d != 1) begin errors++; $display("FAIL loop_done: got %0d pulses, want 1", d); end
   endtask

   task automatic test_stop();
      int b, d, d0;
      rand_rom();
      d0 = $urandom_range(1, 2);
      rom[0] = {16'($urandom_range(1, 4)), 8'(d0)};
      rom[1] = {16'($urandom_range(1, 4)), 8'd2};
      run_song(0, 0, 4 + d0*T + 3 + $urandom_range(0, 5), 0, b, d);
      checks++;
      if (d != 0) begin errors++; $display("FAIL stop_done: got %0d pulses, want 0", d); end
   endtask

   task automatic test_start_stop();
      int b, d;
      start = 1'b1;
      stop  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({addr, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL start_stop_idle: got addr=%0d busy=%b done=%b, want 0 0 0", addr, busy, done);
         end
      end
      start = 1'b0;
      stop  = 1'b0;
      rand_rom();
      rom[0] = {16'd2, 8'd2};
      run_song(0, 0, -1, 1, b, d);
   endtask

   task automatic test_random();
      int b, d;
      for (int k = 0; k < 6; k++) begin
         rand_rom();
         run_song(0, 0, -1, 1, b, d);
      end
   endtask

   task automatic test_back_to_back();
      int b, d;
      rand_rom();
      rom[0] = {16'd1, 8'd1};
      run_song(0, 0, -1, 2, b, d);
   endtask

   task automatic test_async_reset();
      int b, d;
      rom[0] = {16'd3, 8'd2}; rom[1] = '0; rom[2] = '0; rom[3] = '0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (frq !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: got frq=%b busy=%b, want 1 1", frq, busy);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({addr, frq, busy, done} !== 5'b0) begin
         errors++;
         $display("FAIL async_reset: got addr=%0d frq=%b busy=%b done=%b, want all 0", addr, frq, busy, done);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_song(0, 0, -1, 0, b, d);
   endtask

   initial begin
      test_reset();
      test_single_note();
      test_rest();
      test_loop();
      test_stop();
      test_start_stop();
      test_random();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
